// File: rtl/cla16_multiword_sequencer.sv
// Multi-word add/subtract built from one 16-bit carry-lookahead slice adder.
// Each RUN cycle handles one 16-bit slice, and a register carries between slices.
module cla16_multiword_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [16*WORDS-1:0] a_i,
  input  logic [16*WORDS-1:0] b_i,
  input  logic                cin_i,
  input  logic                sub_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [16*WORDS-1:0] sum_o,
  output logic                cout_o,
  output logic                ovf_o,
  output logic                busy_o
);

  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q;
  logic [WORDS-1:0][15:0] a_q;
  logic [WORDS-1:0][15:0] b_q;
  logic [WORDS-1:0][15:0] sum_q;
  logic                   sub_q;
  logic                   carry_q;
  logic [IdxW-1:0]        idx_q;
  logic                   cout_q;
  logic                   ovf_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;

  // Slice adder operands
  logic [15:0] slice_a;
  logic [15:0] slice_b;
  logic [15:0] slice_s;
  logic [15:0] carry;
  logic [15:0] gen;
  logic [15:0] prop;
  logic        grp_c;
  logic        last_slice;

  assign slice_a    = a_q[idx_q];
  assign slice_b    = b_q[idx_q] ^ {16{sub_q}};
  assign last_slice = (idx_q == IdxW'(WORDS - 1));

  // Four 4-bit lookahead groups, rippled group to group.
  always_comb begin
    gen   = slice_a & slice_b;
    prop  = slice_a ^ slice_b;
    carry = '0;
    grp_c = carry_q;
    for (int k = 0; k < 4; k++) begin
      carry[4*k]   = gen[4*k] | (prop[4*k] & grp_c);
      carry[4*k+1] = gen[4*k+1] | (prop[4*k+1] & gen[4*k])
                   | (prop[4*k+1] & prop[4*k] & grp_c);
      carry[4*k+2] = gen[4*k+2] | (prop[4*k+2] & gen[4*k+1])
                   | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                   | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & grp_c);
      carry[4*k+3] = gen[4*k+3] | (prop[4*k+3] & gen[4*k+2])
                   | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                   | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k])
                   | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & prop[4*k] & grp_c);
      grp_c = carry[4*k+3];
    end
    slice_s = prop ^ {carry[14:0], carry_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            a_q        <= a_i;
            b_q        <= b_i;
            sub_q      <= sub_i;
            // Subtract is A + ~B + ~cin, so the borrow-in inverts into the carry.
            carry_q    <= cin_i ^ sub_i;
            idx_q      <= '0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          sum_q[idx_q] <= slice_s;
          carry_q      <= carry[15];
          if (last_slice) begin
            cout_q      <= carry[15];
            ovf_q       <= carry[15] ^ carry[14];
            idx_q       <= '0;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_cla16_multiword_sequencer.sv
// Directed bench for the 4-word sequencer: arithmetic corners, latency, backpressure, reset.
module tb_cla16_multiword_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  cla16_multiword_sequencer #(.WORDS(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .sub_i       (sub),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .ovf_o       (ovf),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid after an accept edge and checks the slice latency.
  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
  endtask

  task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                        input logic ci, input logic sb, input logic [63:0] es,
                        input logic ec, input logic eo);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
    wait_done(tag);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_handover"}, 64'({out_valid, in_ready, busy}), 64'b010);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_flags", 64'({cout, ovf, busy}), 64'd0);

    run_op("ripple", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h0001_0000_0000_0000, 1'b0, 1'b0);
    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    run_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_noborrow", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
    run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Backpressure: hold DONE with a competing request pending.
    a = 64'd1; b = 64'd2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done("bp");
    a = 64'd10; b = 64'd20; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_sum", sum, 64'd3);
      check("bp_hold_flags", 64'({out_valid, in_ready, busy}), 64'b101);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release", 64'({out_valid, in_ready, busy}), 64'b010);
    step();
    in_valid = 1'b0;
    check("bp_new_accept", 64'({in_ready, busy}), 64'b01);
    wait_done("bp2");
    check("bp2_sum", sum, 64'd30);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset after two slices have been written.
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_state", 64'({in_ready, out_valid, busy}), 64'b100);
    check("midrst_sum", sum, 64'd0);
    run_op("post_rst", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
